// File: rtl/pixel_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the pixel array frame sequencer.
package pixel_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_RD_SEL,
        ST_RD_CAP,
        ST_RD_OUT,
        ST_DONE
    } ctrl_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to represent 0..v, never fewer than one.
    function automatic int unsigned bits_for(input int unsigned v);
        return (v < 2) ? 1 : int'($clog2(v + 1));
    endfunction

endpackage

// File: rtl/pixel_array_controller_phase_timer.sv
// Loadable saturating down-counter with a zero flag, shared by the timed phases.
module phase_timer #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/pixel_array_controller.sv
// Frame sequencer: erase -> expose -> convert -> per-pixel select/capture/stream,
// with registered strobes and a valid/ready output port.
module pixel_array_controller #(
    parameter int unsigned pixel_count    = 4,
    parameter int unsigned counter_width  = 8,
    parameter int unsigned erase_cycles   = 4,
    parameter int unsigned convert_cycles = 2 ** counter_width,
    parameter int unsigned expose_width   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [expose_width-1:0]        expose_time,
    output logic                           busy,
    output logic                           erase,
    output logic                           expose,
    output logic                           convert,
    output logic                           read,
    output logic [$clog2(pixel_count)-1:0] pixel_select,
    input  logic [counter_width-1:0]       data_in,
    output logic [counter_width-1:0]       pix_data,
    output logic [$clog2(pixel_count)-1:0] pix_index,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic                           frame_done
);

    import pixel_ctrl_pkg::*;

    localparam int unsigned SEL_W = $clog2(pixel_count);
    localparam int unsigned TW    = bits_for(max_u(convert_cycles, (2 ** expose_width) - 1));

    localparam logic [SEL_W-1:0]        LAST_IDX     = SEL_W'(pixel_count - 1);
    localparam logic [TW-1:0]           ERASE_LOAD   = TW'(erase_cycles - 1);
    localparam logic [TW-1:0]           CONVERT_LOAD = TW'(convert_cycles - 1);
    localparam logic [expose_width-1:0] EXP_ONE      = expose_width'(1);

    ctrl_state_t             state_q, state_d;
    logic [SEL_W-1:0]        idx_q, idx_d;
    logic [expose_width-1:0] exp_len_q, exp_len_d;

    logic                    tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0]           tmr_val;

    logic                    busy_q, erase_q, expose_q, convert_q, read_q;
    logic                    frame_done_q, pix_valid_q;
    logic [SEL_W-1:0]        pixel_select_q, pix_index_q;
    logic [counter_width-1:0] pix_data_q;

    phase_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    // Timer is loaded with (length - 1) on phase entry, so zero marks the last cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        exp_len_d = exp_len_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_val   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ERASE;
                    exp_len_d = (expose_time == '0) ? EXP_ONE : expose_time;
                    tmr_load  = 1'b1;
                    tmr_val   = ERASE_LOAD;
                end
            end
            ST_ERASE: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d  = ST_EXPOSE;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(exp_len_q - EXP_ONE);
                end
            end
            ST_EXPOSE: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d  = ST_CONVERT;
                    tmr_load = 1'b1;
                    tmr_val  = CONVERT_LOAD;
                end
            end
            ST_CONVERT: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_RD_SEL;
                    idx_d   = '0;
                end
            end
            ST_RD_SEL: state_d = ST_RD_CAP;
            ST_RD_CAP: state_d = ST_RD_OUT;
            ST_RD_OUT: begin
                if (pix_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD_SEL;
                        idx_d   = idx_q + SEL_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so each is a clean register output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            exp_len_q      <= '0;
            busy_q         <= 1'b0;
            erase_q        <= 1'b0;
            expose_q       <= 1'b0;
            convert_q      <= 1'b0;
            read_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            pix_valid_q    <= 1'b0;
            pixel_select_q <= '0;
            pix_index_q    <= '0;
            pix_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            exp_len_q    <= exp_len_d;
            busy_q       <= (state_d != ST_IDLE);
            erase_q      <= (state_d == ST_ERASE);
            expose_q     <= (state_d == ST_EXPOSE);
            convert_q    <= (state_d == ST_CONVERT);
            read_q       <= (state_d inside {ST_RD_SEL, ST_RD_CAP, ST_RD_OUT});
            frame_done_q <= (state_d == ST_DONE);
            if (state_d == ST_RD_SEL) begin
                pixel_select_q <= idx_d;
            end
            if (state_q == ST_RD_CAP) begin
                pix_data_q  <= data_in;
                pix_index_q <= idx_q;
                pix_valid_q <= 1'b1;
            end else if ((state_q == ST_RD_OUT) && pix_ready) begin
                pix_valid_q <= 1'b0;
            end
        end
    end

    assign busy         = busy_q;
    assign erase        = erase_q;
    assign expose       = expose_q;
    assign convert      = convert_q;
    assign read         = read_q;
    assign frame_done   = frame_done_q;
    assign pix_valid    = pix_valid_q;
    assign pixel_select = pixel_select_q;
    assign pix_index    = pix_index_q;
    assign pix_data     = pix_data_q;

endmodule
